// File: rtl/cen_gen_pkg.sv
// Shared types and helpers for the multi-channel fractional clock-enable generator.
package cen_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Width of the default-configuration accumulator sum (one bit wider than num/den).
  localparam int ACC_W_DEF = 16;
  typedef logic [ACC_W_DEF:0] sum_t;

  // Channel index width, never below one bit so a single channel still has a select.
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cen_gen_ch.sv
// One fractional clock-enable channel: num/den registers and a modulo-den accumulator
// that emits a pulse each time the running sum wraps past den.
module cen_gen_ch #(
  parameter int ACC_W = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             hold,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_num,
  input  logic [ACC_W-1:0] wr_den,
  output logic             cen
);

  typedef logic [ACC_W:0] ch_sum_t;

  logic [ACC_W-1:0] num_reg;
  logic [ACC_W-1:0] den_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] num_eff;
  ch_sum_t          sum;
  ch_sum_t          den_ext;

  // Clamping num to den turns an over-unity ratio into a steady-high enable.
  assign num_eff = (num_reg > den_reg) ? den_reg : num_reg;
  assign sum     = {1'b0, acc_reg} + {1'b0, num_eff};
  assign den_ext = {1'b0, den_reg};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      num_reg <= '0;
      den_reg <= '0;
      acc_reg <= '0;
      cen     <= 1'b0;
    end else if (wr) begin
      num_reg <= wr_num;
      den_reg <= wr_den;
      acc_reg <= '0;
      cen     <= 1'b0;
    end else if (clr) begin
      acc_reg <= '0;
      cen     <= 1'b0;
    end else if (run && !hold && (den_reg != '0)) begin
      if (sum >= den_ext) begin
        acc_reg <= ACC_W'(sum - den_ext);
        cen     <= 1'b1;
      end else begin
        acc_reg <= sum[ACC_W-1:0];
        cen     <= 1'b0;
      end
    end else begin
      cen <= 1'b0;
    end
  end

endmodule

// File: rtl/cen_gen_multi.sv
// NUM_CH fractional clock-enable generators gated by a PLL-lock settle FSM.
// Optional macro CEN_GEN_PAUSE_EN adds pause/pause_mask to freeze selected channels.
module cen_gen_multi
  import cen_gen_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ACC_W    = 16,
  parameter int LOCK_DLY = 1024
) (
  input  logic                        refclk,
  input  logic                        rst,
  input  logic                        pll_locked,
  input  logic                        cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]            cfg_num,
  input  logic [ACC_W-1:0]            cfg_den,
`ifdef CEN_GEN_PAUSE_EN
  input  logic                        pause,
  input  logic [NUM_CH-1:0]           pause_mask,
`endif
  output logic [NUM_CH-1:0]           cen,
  output logic                        ready
);

  localparam int CH_W  = ch_idx_w(NUM_CH);
  localparam int CNT_W = (LOCK_DLY <= 2) ? 1 : $clog2(LOCK_DLY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DLY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt_reg;
  logic             run;
  logic             leaving;
  logic [NUM_CH-1:0] hold;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_LOCK;
      cnt_reg <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          if (pll_locked) begin
            state   <= SETTLE;
            cnt_reg <= '0;
          end
        end
        SETTLE: begin
          if (!pll_locked) begin
            state <= WAIT_LOCK;
          end else if (cnt_reg == CNT_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (!pll_locked) state <= WAIT_LOCK;
          else             ready <= 1'b1;
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  // Channels only advance on edges that keep the FSM in RUN; any lock loss zeroes them.
  assign run     = (state == RUN) && pll_locked;
  assign leaving = (state != WAIT_LOCK) && !pll_locked;

`ifdef CEN_GEN_PAUSE_EN
  assign hold = pause ? pause_mask : '0;
`else
  assign hold = '0;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr;
    assign wr = cfg_we && (cfg_ch == CH_W'(gi));

    cen_gen_ch #(
      .ACC_W(ACC_W)
    ) u_ch (
      .refclk (refclk),
      .rst    (rst),
      .run    (run),
      .clr    (leaving),
      .hold   (hold[gi]),
      .wr     (wr),
      .wr_num (cfg_num),
      .wr_den (cfg_den),
      .cen    (cen[gi])
    );
  end

endmodule

// File: doc/cen_gen_multi.md
Name: cen_gen_multi

Overview:
- Parametrised successor to the fixed-output PLL wrapper.
- Generates NUM_CH independent fractional clock-enable pulse streams (num/den per channel) from one fast master clock. Replaces per-frequency PLL outputs, e.g. 3/12/36 MHz from 72 MHz.
- Gates all enables until the upstream PLL lock has been stable for LOCK_DLY cycles.
- Ratios are runtime-programmable through a simple write port; sits between the PLL wrapper and the core.

Parameters:
- NUM_CH, 4, number of enable channels (1..16)
- ACC_W, 16, width of num/den/accumulator per channel
- LOCK_DLY, 1024, refclk cycles pll_locked must stay high before enables run (>=1)

Ports:
- refclk  in  1  master clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  upstream PLL lock (already synchronous to refclk)
- cfg_we  in  1  write strobe, one cycle
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write
- cfg_num  in  ACC_W  numerator (pulses per den cycles)
- cfg_den  in  ACC_W  denominator
- cen  out  NUM_CH  per-channel clock-enable pulses, registered
- ready  out  1  high while state==RUN, registered

Behaviour:
- Reset: state=WAIT_LOCK; all num/den/acc cleared; cen=0; ready=0; settle counter=0.
- FSM:
  - WAIT_LOCK: pll_locked=1 -> SETTLE with counter=0.
  - SETTLE: counter increments each cycle; pll_locked=0 -> WAIT_LOCK; counter==LOCK_DLY-1 with pll_locked=1 -> RUN.
  - RUN: pll_locked=0 -> WAIT_LOCK.
- Any exit to WAIT_LOCK clears every acc. cen is 0 from the cycle after the exit. num/den are retained.
- ready=1 exactly in the cycles where registered state is RUN; ready rises one cycle after the final SETTLE cycle.
- Per channel, evaluated only in RUN with den!=0, every cycle:
  - s = acc + num_eff, where num_eff = min(num, den), computed at ACC_W+1 bits.
  - If s >= den: acc <= s - den, cen[ch] <= 1. Otherwise acc <= s, cen[ch] <= 0.
  - Invariant acc < den, so s < 2*den; no overflow at ACC_W+1 bits.
- den==0: channel disabled; cen[ch]=0 and acc held at 0.
- num>den: clamped to den, giving cen[ch]=1 every cycle. num==0: cen[ch] never asserts.
- Outside RUN: cen=0, acc frozen (zeroed on entry to WAIT_LOCK).
- Config write (cfg_we=1): num/den of cfg_ch updated and that channel's acc cleared on the same edge. The first evaluation with new values happens in the following cycle, so the first possible pulse appears on cen two edges after the write edge. Other channels are unaffected.
- Writes are accepted in any state. cfg_ch >= NUM_CH is ignored.
- Phase: on entering RUN all accs are 0, so channels with equal ratios are phase-aligned. The first pulse of a channel occurs on its ceil(den/num)-th RUN cycle.
- Write to a channel in the same cycle it would pulse: the write wins (acc cleared, cen=0 next cycle).

Optional Feature:
- CEN_GEN_PAUSE_EN defined:
  - Adds input `pause` (1 bit) and input `pause_mask` (NUM_CH bits).
  - While pause=1 in RUN, masked channels hold acc and output cen=0. Unmasked channels run normally.
  - On release, masked channels resume from the held acc (no phase loss).
  - ready is unaffected.
- Not defined: ports absent; behaviour identical to pause=0.

Decomposition:
- Package cen_gen_pkg:
  - state enum {WAIT_LOCK, SETTLE, RUN}
  - function ch_idx_w(NUM_CH)
  - typedef for the ACC_W+1 sum
- Sub-module cen_gen_ch: one accumulator channel (num/den/acc regs, clamp, pulse). Generated NUM_CH times.
- Top holds the FSM, settle counter and write decode.

Test Plan:
- rst pulsed mid-RUN, then pll_locked=1 held -> cen=0 and ready=0 immediately; ready rises exactly LOCK_DLY+1 cycles after pll_locked seen high.
- LOCK_DLY=8; pll_locked drops at settle count 5 -> back to WAIT_LOCK, ready stays 0; counter restarts from 0 on the next lock.
- ch0 num=1 den=3, ch1 num=3 den=8, ch2 num=1 den=1, ch3 den=0, in RUN:
  - ch0 pulses every 3rd cycle.
  - ch1 gives exactly 3 pulses per 8 cycles with pattern 0,0,1,0,0,1,0,1 repeating.
  - ch2 stays high every cycle.
  - ch3 never pulses.
- num=5 den=4 -> ch cen high every cycle (clamp). Rewrite num=1 den=2 mid-stream -> cen 0 for one cycle, then alternating 0/1 starting with 0.
- pll_locked drops in RUN for 1 cycle -> all cen 0 from next cycle; resumes after LOCK_DLY with all channels phase-realigned (equal-ratio channels pulse on identical cycles).
- (CEN_GEN_PAUSE_EN) pause=1 mask=4'b0001 for 7 cycles on ch0 num=1 den=3 -> ch0 silent, others unchanged; after release ch0 next pulse spacing continues from the held acc.
